// File: rtl/fetch_seq_pkg.sv
// Shared types and default parameters for the instruction fetch sequencer.
package fetch_seq_pkg;

  localparam int              AW_DEF          = 8;
  localparam int              DW_DEF          = 8;
  localparam int              BUF_DEPTH_DEF   = 2;
  localparam logic [7:0]      START_PC_DEF    = 8'h00;
  localparam logic [7:0]      HALT_OPCODE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small response buffer holding {pc, instr} pairs between the fetch unit and decode.
module fetch_skid_fifo
  import fetch_seq_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = BUF_DEPTH_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [AW-1:0] i_pushPc,
  input  logic [DW-1:0] i_pushInstr,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output logic          o_headValid,
  output logic [AW-1:0] o_headPc,
  output logic [DW-1:0] o_headInstr
);

  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  // Flush discards everything; a push and pop together on a full buffer is legal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= {i_pushPc, i_pushInstr};
        r_wrPtr        <= r_wrPtr + PW'(1);
      end
      if (i_pop) r_rdPtr <= r_rdPtr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_headValid = (r_count != '0);
  assign o_headPc    = r_mem[r_rdPtr][AW+DW-1:DW];
  assign o_headInstr = r_mem[r_rdPtr][DW-1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the program counter, issues fetches with buffer credit, and hands
// buffered instructions to decode; handles start, redirect and halt.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int            AW          = AW_DEF,
  parameter int            DW          = DW_DEF,
  parameter logic [AW-1:0] START_PC    = START_PC_DEF,
  parameter logic [DW-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int            BUF_DEPTH   = BUF_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] pc,
  input  logic [DW-1:0] fetch_instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          running,
  output logic          halted
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t  r_state;
  fetch_state_t  w_nextState;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_tag;
  logic          r_inflight;
  logic [CW-1:0] w_count;
  logic          w_pop;
  logic          w_push;
  logic          w_haltAccept;
  logic          w_flush;
  logic          w_issue;
  logic [CW:0]   w_used;
  logic [CW:0]   w_limit;

  assign w_pop        = instr_valid & instr_ready;
  assign w_haltAccept = (r_state == RUN) & w_pop & (instr == HALT_OPCODE);
  assign w_flush      = redirect_valid | w_haltAccept;
  assign w_push       = r_inflight & ~w_flush;

  // The slot popped this cycle is free again by the time the new response lands.
  assign w_used  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_limit = (CW + 1)'(BUF_DEPTH) + {{CW{1'b0}}, w_pop};
  assign w_issue = (r_state == RUN) & ~redirect_valid & ~w_haltAccept & (w_used < w_limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (start)        w_nextState = RUN;
      RUN:     if (w_haltAccept) w_nextState = HALTED;
      HALTED:  if (start)        w_nextState = RUN;
      default:                   w_nextState = IDLE;
    endcase
  end

  always_comb begin
    running = (r_state == RUN);
    halted  = (r_state == HALTED);
  end

  // Redirect takes priority over the halt resume point for the next PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= START_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (redirect_valid)    r_pc <= redirect_pc;
      else if (w_haltAccept) r_pc <= instr_pc + AW'(1);
      else if (w_issue)      r_pc <= r_pc + AW'(1);
      if (w_issue) r_tag <= r_pc;
      r_inflight <= w_issue;
    end
  end

  assign pc = r_pc;

  fetch_skid_fifo #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pushPc    (r_tag),
    .i_pushInstr (fetch_instr),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_count     (w_count),
    .o_headValid (instr_valid),
    .o_headPc    (instr_pc),
    .o_headInstr (instr)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run, all
// checked against a stream-level model of which instruction decode should see next.
module tb_fetch_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [7:0] pc;
  logic [7:0] fetch_instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       running;
  logic       halted;

  logic [7:0] mem [256];

  int         nCompared;
  int         nMismatched;
  int         mState;
  int         gap;
  int         nAcc;
  int         n;
  logic [7:0] expPc;
  logic [7:0] pcMid;

  logic       sValid;
  logic [7:0] sPc;
  logic [7:0] sInstr;
  logic       sHalted;
  logic [7:0] sPcOut;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .fetch_instr    (fetch_instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .running        (running),
    .halted         (halted)
  );

  // Fetch unit: returns memory[pc] one clock after the address is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fetch_instr <= 8'h00;
    else       fetch_instr <= mem[pc];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    instr_ready    = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstValid",   32'(instr_valid), 32'(0));
    checkOutput("rstPc",      32'(pc),          32'(8'h00));
    checkOutput("rstInstr",   32'(instr),       32'(0));
    checkOutput("rstInstrPc", 32'(instr_pc),    32'(0));
    checkOutput("rstRunning", 32'(running),     32'(0));
    checkOutput("rstHalted",  32'(halted),      32'(0));
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    mState = M_IDLE;
    expPc  = 8'h00;
    gap    = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic applyStimulus(input logic s, input logic rv, input logic [7:0] rpc, input logic rdy);
    logic accepted;
    @(negedge clk);
    start          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    sValid  = instr_valid;
    sPc     = instr_pc;
    sInstr  = instr;
    sHalted = halted;
    sPcOut  = pc;
    checkOutput("running", 32'(running), 32'(mState == M_RUN));
    checkOutput("halted",  32'(halted),  32'(mState == M_HALT));
    if (mState != M_RUN) begin
      checkOutput("noValid", 32'(instr_valid), 32'(0));
      checkOutput("restPc",  32'(pc),          32'(expPc));
    end
    if (instr_valid) begin
      checkOutput("instrPc", 32'(instr_pc), 32'(expPc));
      checkOutput("instr",   32'(instr),    32'(mem[expPc]));
      gap = 0;
    end else if (mState == M_RUN) begin
      gap++;
      checkOutput("gapOk", 32'(gap <= 2), 32'(1));
    end
    if (rv) gap = 0;
    accepted = sValid && rdy;
    @(posedge clk);
    if (accepted && mem[expPc] == 8'hFF) mState = M_HALT;
    else if (s && mState != M_RUN)       mState = M_RUN;
    if (accepted) begin
      expPc = expPc + 8'd1;
      nAcc++;
    end
    if (rv) expPc = rpc;
  endtask

  task automatic waitValid(input logic rdy, output int cycles);
    cycles = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 8'h00, rdy);
      cycles++;
    end while (!sValid && cycles < 8);
    if (!sValid) cycles = 99;
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    instr_ready    = 1'b0;
    nCompared      = 0;
    nMismatched    = 0;
    nAcc           = 0;
    mState         = M_IDLE;
    expPc          = 8'h00;
    gap            = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
    mem[8'h00] = 8'h11;
    mem[8'h01] = 8'h22;
    mem[8'h02] = 8'h33;
    mem[8'h03] = 8'h44;
    mem[8'h05] = 8'hFF;
    mem[8'hFE] = 8'hA1;
    mem[8'hFF] = 8'hB2;
    resetDut();

    $display("[TB] start latency and back-to-back stream");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("t1Valid", 32'(sValid), 32'(c >= 3));
      if (c >= 3) checkOutput("t1Pc", 32'(sPc), 32'(c - 3));
      if (c == 3) checkOutput("t1Instr", 32'(sInstr), 32'(8'h11));
    end

    $display("[TB] decode stall");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("t2Head", 32'(sPc), 32'(8'h04));
      if (k == 2) pcMid = sPcOut;
      if (k == 4) begin
        checkOutput("t2PcStall", 32'(sPcOut), 32'(pcMid));
        checkOutput("t2PcValue", 32'(sPcOut), 32'(8'h06));
      end
    end

    $display("[TB] halt opcode at pc 5");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("t4Pc4", 32'(sPc), 32'(8'h04));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("t4HaltPc",    32'(sPc),    32'(8'h05));
    checkOutput("t4HaltInstr", 32'(sInstr), 32'(8'hFF));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("t4Halted",   32'(sHalted), 32'(1));
    checkOutput("t4ResumePc", 32'(sPcOut),  32'(8'h06));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitValid(1'b0, n);
    checkOutput("t4Lat",  32'(n),   32'(3));
    checkOutput("t4Pc6",  32'(sPc), 32'(8'h06));

    $display("[TB] redirect with full buffer");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h40, 1'b0);
    waitValid(1'b1, n);
    checkOutput("t3Lat",   32'(n),      32'(3));
    checkOutput("t3Pc",    32'(sPc),    32'(8'h40));
    checkOutput("t3Instr", 32'(sInstr), 32'(mem[8'h40]));

    $display("[TB] pc wrap-around");
    mem[8'h00] = 8'hC3;
    applyStimulus(1'b0, 1'b1, 8'hFE, 1'b1);
    waitValid(1'b1, n);
    checkOutput("t5Lat",    32'(n),      32'(3));
    checkOutput("t5PcFE",   32'(sPc),    32'(8'hFE));
    checkOutput("t5InstA1", 32'(sInstr), 32'(8'hA1));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("t5PcFF",   32'(sPc),    32'(8'hFF));
    checkOutput("t5InstB2", 32'(sInstr), 32'(8'hB2));
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("t5Pc00",   32'(sPc),    32'(8'h00));
    checkOutput("t5InstC3", 32'(sInstr), 32'(8'hC3));

    $display("[TB] reset mid-run, then halt plus redirect");
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    resetDut();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("t6IdleValid", 32'(sValid), 32'(0));
    applyStimulus(1'b0, 1'b1, 8'h05, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    waitValid(1'b0, n);
    checkOutput("t6Lat",   32'(n),      32'(3));
    checkOutput("t6Pc5",   32'(sPc),    32'(8'h05));
    checkOutput("t6InstF", 32'(sInstr), 32'(8'hFF));
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("t6Halted", 32'(sHalted), 32'(1));
    checkOutput("t6PcOut",  32'(sPcOut),  32'(8'h10));
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    waitValid(1'b1, n);
    checkOutput("t6ResLat", 32'(n),   32'(3));
    checkOutput("t6ResPc",  32'(sPc), 32'(8'h10));

    $display("[TB] randomized run");
    resetDut();
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    nAcc = 0;
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 7) == 0,
                    $urandom_range(0, 39) == 0,
                    8'($urandom_range(0, 255)),
                    $urandom_range(0, 3) != 0);
    end
    checkOutput("randProgress", 32'(nAcc > 200), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
